// File: rtl/conf_loader_pkg.sv
// Shared constants, header/payload field positions and FSM encoding for the
// PE configuration loader.
package conf_loader_pkg;

  localparam int CONF_ALU_W = 4;
  localparam int CONF_SEL_W = 3;
  localparam int CONF_SE_W  = 10;
  localparam int CONF_W     = CONF_ALU_W + 2 * CONF_SEL_W + CONF_SE_W;

  localparam logic [3:0] HDR_OP = 4'hA;

  localparam int HDR_OP_HI    = 31;
  localparam int HDR_OP_LO    = 28;
  localparam int HDR_START_HI = 15;
  localparam int HDR_START_LO = 8;
  localparam int HDR_COUNT_HI = 7;
  localparam int HDR_COUNT_LO = 0;

  localparam int PL_HI = CONF_W - 1;
  localparam int PL_LO = 0;

  // Field order matches the payload word, so a payload slice casts directly.
  typedef struct packed {
    logic [CONF_ALU_W-1:0] alu;
    logic [CONF_SEL_W-1:0] sel_a;
    logic [CONF_SEL_W-1:0] sel_b;
    logic [CONF_SE_W-1:0]  se;
  } conf_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/conf_loader_bank.sv
// One PE's configuration storage: a shadow register written by the loader and
// an active register that takes the shadow value on commit.
module conf_bank
  import conf_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  wr_en,
  input  logic  commit,
  input  conf_t wr_data,
  output conf_t active
);

  conf_t shadow_reg;
  conf_t active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      active_reg <= '0;
    end else begin
      if (wr_en) shadow_reg <= wr_data;
      if (commit) active_reg <= shadow_reg;
    end
  end

  assign active = active_reg;

endmodule

// File: rtl/conf_loader.sv
// Host-driven configuration loader: parses header/payload bursts into per-PE
// shadow registers and commits them to the active bank atomically.
module conf_loader
  import conf_loader_pkg::*;
#(
  parameter int NPE = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_err_clr,
  output logic [NPE*CONF_ALU_W-1:0] out_conf_alu,
  output logic [NPE*CONF_SEL_W-1:0] out_conf_sel_a,
  output logic [NPE*CONF_SEL_W-1:0] out_conf_sel_b,
  output logic [NPE*CONF_SE_W-1:0]  out_conf_se,
  output logic                      out_busy,
  output logic                      out_commit,
  output logic                      out_err
);

  localparam logic [8:0] NPE_9 = 9'(NPE);

  state_t     state_reg, state_next;
  logic [7:0] ptr_reg, ptr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic       err_reg, err_next;
  logic       load_we;
  logic       commit;
  logic       err_event;

  logic [3:0] hdr_op;
  logic [7:0] hdr_start;
  logic [7:0] hdr_count;
  logic [8:0] hdr_sum;
  conf_t      payload;
  logic       unused_bits;

  assign hdr_op      = in_data[HDR_OP_HI:HDR_OP_LO];
  assign hdr_start   = in_data[HDR_START_HI:HDR_START_LO];
  assign hdr_count   = in_data[HDR_COUNT_HI:HDR_COUNT_LO];
  assign hdr_sum     = {1'b0, hdr_start} + {1'b0, hdr_count};
  assign payload     = conf_t'(in_data[PL_HI:PL_LO]);
  assign unused_bits = ^in_data[27:20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    load_we    = 1'b0;
    commit     = 1'b0;
    err_event  = 1'b0;
    in_ready   = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (hdr_op != HDR_OP || hdr_count == 8'd0) begin
            err_event = 1'b1;
          end else if (hdr_sum > NPE_9) begin
            // Overrunning burst: flag it but still swallow its payload words.
            err_event  = 1'b1;
            cnt_next   = hdr_count;
            state_next = ST_DRAIN;
          end else begin
            ptr_next   = hdr_start;
            cnt_next   = hdr_count;
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          load_we  = 1'b1;
          ptr_next = ptr_reg + 8'd1;
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) state_next = ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        if (in_valid) begin
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) state_next = ST_IDLE;
        end
      end
      ST_COMMIT: begin
        in_ready   = 1'b0;
        commit     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A new error outranks a simultaneous clear.
    if (err_event) err_next = 1'b1;
    else if (in_err_clr) err_next = 1'b0;
  end

  assign out_busy   = (state_reg != ST_IDLE);
  assign out_commit = commit;
  assign out_err    = err_reg;

  for (genvar gi = 0; gi < NPE; gi++) begin : g_pe
    conf_t bank_active;

    conf_bank u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (load_we && (ptr_reg == 8'(gi))),
      .commit  (commit),
      .wr_data (payload),
      .active  (bank_active)
    );

    assign out_conf_alu[gi*CONF_ALU_W +: CONF_ALU_W]   = bank_active.alu;
    assign out_conf_sel_a[gi*CONF_SEL_W +: CONF_SEL_W] = bank_active.sel_a;
    assign out_conf_sel_b[gi*CONF_SEL_W +: CONF_SEL_W] = bank_active.sel_b;
    assign out_conf_se[gi*CONF_SE_W +: CONF_SE_W]      = bank_active.se;
  end

endmodule

// File: tb/tb_conf_loader.sv
// Directed self-checking bench for conf_loader with NPE=8.
module tb_conf_loader;

  localparam int NPE = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_err_clr = 1'b0;
  logic [NPE*4-1:0]  out_conf_alu;
  logic [NPE*3-1:0]  out_conf_sel_a;
  logic [NPE*3-1:0]  out_conf_sel_b;
  logic [NPE*10-1:0] out_conf_se;
  logic              out_busy;
  logic              out_commit;
  logic              out_err;

  logic [NPE*4-1:0]  exp_alu = '0;
  logic [NPE*3-1:0]  exp_sa = '0;
  logic [NPE*3-1:0]  exp_sb = '0;
  logic [NPE*10-1:0] exp_se = '0;
  int cmp = 0;
  int mis = 0;
  int commit_cnt = 0;
  int commit_base;

  conf_loader #(.NPE(NPE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_err_clr     (in_err_clr),
    .out_conf_alu   (out_conf_alu),
    .out_conf_sel_a (out_conf_sel_a),
    .out_conf_sel_b (out_conf_sel_b),
    .out_conf_se    (out_conf_se),
    .out_busy       (out_busy),
    .out_commit     (out_commit),
    .out_err        (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_commit) commit_cnt++;

  // Present a word with in_valid high and return just after the accepting edge.
  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    in_data = w;
    in_valid = 1'b1;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    cmp++;
    if (in_ready !== 1'b1) begin
      mis++;
      $display("FAIL send_ready word=%h: ready=%b want 1", w, in_ready);
    end
    @(posedge clk);
    #1;
    $display("sent word %h busy=%b err=%b", w, out_busy, out_err);
  endtask

  task automatic stop();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    cmp++;
    if ({out_busy, out_commit, out_err, in_ready} !== 4'b0001) begin
      mis++;
      $display("FAIL reset_ctl: busy/commit/err/ready=%b want 0001",
               {out_busy, out_commit, out_err, in_ready});
    end
    cmp++;
    if ({out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se} !== '0) begin
      mis++;
      $display("FAIL reset_conf: alu=%h se=%h want 0", out_conf_alu, out_conf_se);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_burst();
    commit_base = commit_cnt;
    send(32'hA000_0003);
    send(32'h000A_1234);
    send(32'h0005_5555);
    send(32'h000F_FFFF);
    stop();
    cmp++;
    if ({out_commit, in_ready, out_busy} !== 3'b101) begin
      mis++;
      $display("FAIL burst_commit_cycle: commit/ready/busy=%b want 101",
               {out_commit, in_ready, out_busy});
    end
    cmp++;
    if (out_conf_alu !== '0) begin
      mis++;
      $display("FAIL burst_early_update: alu=%h want 0", out_conf_alu);
    end
    @(posedge clk);
    #1;
    exp_alu[3:0] = 4'hA;   exp_sa[2:0] = 3'd0; exp_sb[2:0] = 3'd4; exp_se[9:0]   = 10'h234;
    exp_alu[7:4] = 4'h5;   exp_sa[5:3] = 3'd2; exp_sb[5:3] = 3'd5; exp_se[19:10] = 10'h155;
    exp_alu[11:8] = 4'hF;  exp_sa[8:6] = 3'd7; exp_sb[8:6] = 3'd7; exp_se[29:20] = 10'h3FF;
    cmp++;
    if ({out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se} !==
        {exp_alu, exp_sa, exp_sb, exp_se}) begin
      mis++;
      $display("FAIL burst_conf: alu=%h sa=%h sb=%h se=%h want alu=%h sa=%h sb=%h se=%h",
               out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se,
               exp_alu, exp_sa, exp_sb, exp_se);
    end
    cmp++;
    if ({out_commit, out_busy, out_err, commit_cnt - commit_base} !== {3'b000, 32'd1}) begin
      mis++;
      $display("FAIL burst_after: commit/busy/err=%b commits=%0d want 000 and 1",
               {out_commit, out_busy, out_err}, commit_cnt - commit_base);
    end
  endtask

  task automatic test_partial();
    send(32'hA000_0601);
    send(32'h0003_0000);
    stop();
    @(posedge clk);
    #1;
    exp_alu[27:24] = 4'h3;
    cmp++;
    if ({out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se} !==
        {exp_alu, exp_sa, exp_sb, exp_se}) begin
      mis++;
      $display("FAIL partial_conf: alu=%h se=%h want alu=%h se=%h",
               out_conf_alu, out_conf_se, exp_alu, exp_se);
    end
  endtask

  task automatic test_overrun();
    commit_base = commit_cnt;
    send(32'hA000_0703);
    cmp++;
    if ({out_err, out_busy} !== 2'b11) begin
      mis++;
      $display("FAIL overrun_hdr: err/busy=%b want 11", {out_err, out_busy});
    end
    send(32'h000B_1111);
    send(32'h000C_2222);
    send(32'h000D_3333);
    stop();
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if ({out_err, out_busy, commit_cnt - commit_base} !== {2'b10, 32'd0}) begin
      mis++;
      $display("FAIL overrun_end: err/busy=%b commits=%0d want 10 and 0",
               {out_err, out_busy}, commit_cnt - commit_base);
    end
    cmp++;
    if ({out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se} !==
        {exp_alu, exp_sa, exp_sb, exp_se}) begin
      mis++;
      $display("FAIL overrun_conf: alu=%h want %h", out_conf_alu, exp_alu);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    in_err_clr = 1'b1;
    @(posedge clk);
    #1;
    in_err_clr = 1'b0;
  endtask

  task automatic test_errors();
    pulse_clr();
    cmp++;
    if (out_err !== 1'b0) begin
      mis++;
      $display("FAIL err_clear1: err=%b want 0", out_err);
    end
    send(32'h5000_0001);
    stop();
    cmp++;
    if ({out_err, out_busy} !== 2'b10) begin
      mis++;
      $display("FAIL bad_opcode: err/busy=%b want 10", {out_err, out_busy});
    end
    pulse_clr();
    cmp++;
    if (out_err !== 1'b0) begin
      mis++;
      $display("FAIL err_clear2: err=%b want 0", out_err);
    end
    send(32'hA000_0000);
    stop();
    cmp++;
    if ({out_err, out_busy} !== 2'b10) begin
      mis++;
      $display("FAIL zero_count: err/busy=%b want 10", {out_err, out_busy});
    end
    pulse_clr();
    in_err_clr = 1'b1;
    send(32'h3000_0001);
    stop();
    in_err_clr = 1'b0;
    cmp++;
    if (out_err !== 1'b1) begin
      mis++;
      $display("FAIL err_wins: err=%b want 1", out_err);
    end
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    commit_base = commit_cnt;
    send(32'hA000_0002);
    send(32'h0001_0000);
    stop();
    #2;
    rst_n = 1'b0;
    #1;
    exp_alu = '0; exp_sa = '0; exp_sb = '0; exp_se = '0;
    cmp++;
    if ({out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se,
         out_busy, out_commit, out_err, in_ready} !== {{(NPE*20){1'b0}}, 4'b0001}) begin
      mis++;
      $display("FAIL reset_mid: alu=%h busy/commit/err/ready=%b want 0 and 0001",
               out_conf_alu, {out_busy, out_commit, out_err, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp++;
    if ({commit_cnt - commit_base, out_conf_alu} !== {32'd0, 32'h0}) begin
      mis++;
      $display("FAIL reset_mid_nocommit: commits=%0d alu=%h want 0",
               commit_cnt - commit_base, out_conf_alu);
    end
  endtask

  task automatic test_gaps();
    commit_base = commit_cnt;
    send(32'hA000_0102);
    stop();
    repeat (2) @(posedge clk);
    send(32'h0002_E000);
    stop();
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if ({out_busy, out_commit} !== 2'b10) begin
      mis++;
      $display("FAIL gap_stall: busy/commit=%b want 10", {out_busy, out_commit});
    end
    send(32'h0009_0C01);
    stop();
    @(posedge clk);
    #1;
    exp_alu[7:4] = 4'h2;  exp_sa[5:3] = 3'd7;
    exp_alu[11:8] = 4'h9; exp_sb[8:6] = 3'd3; exp_se[29:20] = 10'h001;
    cmp++;
    if ({out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se} !==
        {exp_alu, exp_sa, exp_sb, exp_se}) begin
      mis++;
      $display("FAIL gap_conf: alu=%h sa=%h sb=%h se=%h want alu=%h sa=%h sb=%h se=%h",
               out_conf_alu, out_conf_sel_a, out_conf_sel_b, out_conf_se,
               exp_alu, exp_sa, exp_sb, exp_se);
    end
    cmp++;
    if (commit_cnt - commit_base !== 1) begin
      mis++;
      $display("FAIL gap_commits: commits=%0d want 1", commit_cnt - commit_base);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_partial();
    test_overrun();
    test_errors();
    test_reset_mid();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
